// File: rtl/pipelined_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_alu_if
// Purpose  : Valid/ready operand bus and result bus of the pipelined ALU.
//            The master drives operations and consumes results; the slave
//            is the ALU itself.
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_alu_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    // Operation input side
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           opcode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;

    // Result output side
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic                 carry;
    logic                 zero;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, opcode, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, err, err_cnt
    );

    modport slave (
        input  in_valid, opcode, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_alu
// Purpose  : Two-stage valid/ready ALU. S1 registers the operation, S2
//            registers the computed result and flags. Full throughput while
//            the consumer is ready; at most two operations buffered otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_alu #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pipelined_alu_if.slave     bus
);
    // Shift amount uses only the low log2(WIDTH) bits of operand B
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    // Stage 1: captured operation
    logic                 s1_valid_q;
    logic [2:0]           s1_op_q;
    logic [WIDTH-1:0]     s1_a_q;
    logic [WIDTH-1:0]     s1_b_q;

    // Stage 2: computed result and flags
    logic                 s2_valid_q;
    logic [WIDTH-1:0]     result_q;
    logic                 carry_q;
    logic                 zero_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Next-state values computed from S1
    logic [WIDTH-1:0]     result_d;
    logic                 carry_d;
    logic                 zero_d;
    logic                 err_d;

    logic                 advance;
    logic                 in_ready;
    logic                 accept;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;
    logic [SHW-1:0]       shamt_w;

    // S2 (and with it S1) moves whenever S2 is empty or being drained
    assign advance  = !s2_valid_q || bus.out_ready;
    // Held low during reset so nothing is accepted while the block is cleared
    assign in_ready = rst_n && (!s1_valid_q || advance);
    assign accept   = bus.in_valid && in_ready;

    assign sum_w    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_w   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    assign shamt_w  = s1_b_q[SHW-1:0];

    // Operation decode; every opcode value listed, defaults prevent latches
    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        err_d    = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                result_d = sum_w[WIDTH-1:0];
                carry_d  = sum_w[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow (a < b)
                result_d = diff_w[WIDTH-1:0];
                carry_d  = diff_w[WIDTH];
            end
            OP_AND: result_d = s1_a_q & s1_b_q;
            OP_OR:  result_d = s1_a_q | s1_b_q;
            OP_XOR: result_d = s1_a_q ^ s1_b_q;
            OP_SHL: result_d = s1_a_q << shamt_w;
            OP_SHR: result_d = s1_a_q >> shamt_w;
            OP_ILL: err_d    = 1'b1;
        endcase
        zero_d = !err_d && (result_d == '0);
    end

    // S1: load on accept, empty out when its content moves to S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'b000;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= bus.opcode;
            s1_a_q     <= bus.a;
            s1_b_q     <= bus.b;
        end else if (advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    // S2: take S1's computed result; output data only changes on a real load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                zero_q   <= zero_d;
                err_q    <= err_d;
            end
        end
    end

    // Saturating count of illegal operations accepted at the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (accept && (bus.opcode == OP_ILL) && !(&err_cnt_q)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_alu
// Purpose  : Self-checking bench for pipelined_alu (WIDTH=8). Directed
//            vectors plus randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_alu;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    pipelined_alu_if #(.WIDTH(8), .ERR_CNT_W(8)) bus ();

    pipelined_alu #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output entry: value plus the edge on which it was accepted
    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       e;
        int         acc;
    } ent_t;

    ent_t q[$];     // operations accepted and not yet consumed, in order
    int   ecnt;     // number of rising edges modelled so far
    int   ec;       // expected saturating illegal-op count

    // Reference ALU from plain integer arithmetic
    function automatic ent_t ref_op(input int op, input int x, input int y);
        ent_t t;
        int   r;
        t.c = 1'b0; t.e = 1'b0; t.acc = 0; r = 0;
        case (op)
            0: begin r = x + y; t.c = (r > 255); r = r % 256; end
            1: begin t.c = (x < y); r = (x - y + 256) % 256; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (x << (y % 8)) % 256;
            6: r = x >> (y % 8);
            default: t.e = 1'b1;
        endcase
        t.res = r[7:0];
        t.z   = !t.e && (r == 0);
        return t;
    endfunction

    // Advance the model across the coming rising edge using current inputs
    task automatic commit();
        bit   vis, drn, acc_ok;
        ent_t t;
        vis = 1'b0;
        if (q.size() > 0) vis = (ecnt > q[0].acc);
        drn    = vis && bus.out_ready;
        acc_ok = rst_n && bus.in_valid && ((q.size() < 2) || bus.out_ready);
        ecnt++;
        if (drn) void'(q.pop_front());
        if (acc_ok) begin
            t = ref_op(int'(bus.opcode), int'(bus.a), int'(bus.b));
            t.acc = ecnt;
            q.push_back(t);
            if (bus.opcode == 3'b111 && ec < 255) ec++;
        end
    endtask

    // One clock cycle: model update, drive after the edge, return mid-cycle
    task automatic cyc(input logic v, input logic [2:0] op, input logic [7:0] x,
                       input logic [7:0] y, input logic ordy);
        commit();
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.opcode    = op;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        q.delete();
        ec = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.err, bus.in_ready} !== 13'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b r=%h c=%b z=%b e=%b ir=%b exp all 0",
                     bus.out_valid, bus.result, bus.carry, bus.zero, bus.err, bus.in_ready);
        end
        vectors++;
        if (bus.err_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_err_cnt got %h exp 00", bus.err_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got ir=%b v=%b exp ir=1 v=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_arith();
        do_reset();
        cyc(1'b1, 3'b000, 8'h55, 8'h0F, 1'b1);
        cyc(1'b1, 3'b000, 8'hFF, 8'h01, 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL add_latency got out_valid=%b exp 0 one cycle after accept", bus.out_valid);
        end
        cyc(1'b1, 3'b001, 8'h0F, 8'h55, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.err} !== {1'b1, 8'h64, 3'b000}) begin
            miscompares++;
            $display("FAIL add_55_0f got v=%b r=%h c=%b z=%b e=%b exp v=1 r=64 c=0 z=0 e=0",
                     bus.out_valid, bus.result, bus.carry, bus.zero, bus.err);
        end
        cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.err} !== {1'b1, 8'h00, 3'b110}) begin
            miscompares++;
            $display("FAIL add_ff_01 got v=%b r=%h c=%b z=%b e=%b exp v=1 r=00 c=1 z=1 e=0",
                     bus.out_valid, bus.result, bus.carry, bus.zero, bus.err);
        end
        cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
        vectors++;
        if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.err} !== {1'b1, 8'hBA, 3'b100}) begin
            miscompares++;
            $display("FAIL sub_0f_55 got v=%b r=%h c=%b z=%b e=%b exp v=1 r=ba c=1 z=0 e=0",
                     bus.out_valid, bus.result, bus.carry, bus.zero, bus.err);
        end
        cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arith_drain got out_valid=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [5];
        logic [7:0] exp [5];
        ops = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
        exp = '{8'h22, 8'hBB, 8'h99, 8'h50, 8'h15};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 5) cyc(1'b1, ops[i], 8'hAA, 8'h33, 1'b1);
            else       cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
            if (i >= 2) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.result !== exp[i-2] || bus.err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_logic[%0d] got v=%b r=%h e=%b exp v=1 r=%h e=0",
                             i - 2, bus.out_valid, bus.result, bus.err, exp[i-2]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) cyc(1'b1, 3'b111, 8'hA5, 8'h5A, 1'b1);
            else       cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
            if (i >= 2) begin
                vectors++;
                if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.err} !== {1'b1, 8'h00, 3'b001}) begin
                    miscompares++;
                    $display("FAIL illegal[%0d] got v=%b r=%h c=%b z=%b e=%b exp v=1 r=00 c=0 z=0 e=1",
                             i - 2, bus.out_valid, bus.result, bus.carry, bus.zero, bus.err);
                end
            end
        end
        vectors++;
        if (bus.err_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL err_cnt_3 got %h exp 03", bus.err_cnt);
        end
        // Idle inputs carrying an illegal opcode must not count
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'b111, 8'h00, 8'h00, 1'b1);
        vectors++;
        if (bus.err_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL err_cnt_idle got %h exp 03", bus.err_cnt);
        end
        for (int i = 0; i < 297; i++) cyc(1'b1, 3'b111, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
        vectors++;
        if (bus.err_cnt !== 8'hFF) begin
            miscompares++;
            $display("FAIL err_cnt_sat got %h exp ff", bus.err_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_r [8];
        logic       exp_v [8];
        logic       exp_ir[8];
        // A = 01+02 = 03, B = f0^0f = ff, C = 10-01 = 0f
        exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_ir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_r  = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h03, 8'hFF, 8'h0F, 8'h0F};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       cyc(1'b1, 3'b000, 8'h01, 8'h02, 1'b0);
                1:       cyc(1'b1, 3'b100, 8'hF0, 8'h0F, 1'b0);
                2, 3:    cyc(1'b1, 3'b001, 8'h10, 8'h01, 1'b0);
                4:       cyc(1'b1, 3'b001, 8'h10, 8'h01, 1'b1);
                default: cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
            endcase
            vectors++;
            if (bus.out_valid !== exp_v[i] || bus.in_ready !== exp_ir[i] ||
                (exp_v[i] && bus.result !== exp_r[i])) begin
                miscompares++;
                $display("FAIL backpressure[%0d] got v=%b ir=%b r=%h exp v=%b ir=%b r=%h",
                         i, bus.out_valid, bus.in_ready, bus.result, exp_v[i], exp_ir[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_random();
        logic exp_ov, exp_ir;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0));
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (ecnt > q[0].acc);
            exp_ir = (q.size() < 2) || bus.out_ready;
            vectors++;
            if (bus.out_valid !== exp_ov || bus.in_ready !== exp_ir || bus.err_cnt !== 8'(ec)) begin
                miscompares++;
                $display("FAIL rnd_ctrl[%0d] got v=%b ir=%b ec=%0d exp v=%b ir=%b ec=%0d",
                         i, bus.out_valid, bus.in_ready, bus.err_cnt, exp_ov, exp_ir, ec);
            end
            if (exp_ov) begin
                vectors++;
                if ({bus.result, bus.carry, bus.zero, bus.err} !== {q[0].res, q[0].c, q[0].z, q[0].e}) begin
                    miscompares++;
                    $display("FAIL rnd_data[%0d] got r=%h c=%b z=%b e=%b exp r=%h c=%b z=%b e=%b",
                             i, bus.result, bus.carry, bus.zero, bus.err,
                             q[0].res, q[0].c, q[0].z, q[0].e);
                end
            end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        cyc(1'b1, 3'b111, 8'h00, 8'h00, 1'b0);
        cyc(1'b1, 3'b111, 8'h00, 8'h00, 1'b0);
        cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL midrst_full got v=%b ir=%b ec=%h exp v=1 ir=0 ec=02",
                     bus.out_valid, bus.in_ready, bus.err_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.result, bus.err, bus.in_ready, bus.err_cnt} !== 19'b0) begin
            miscompares++;
            $display("FAIL midrst_clear got v=%b r=%h e=%b ir=%b ec=%h exp all 0",
                     bus.out_valid, bus.result, bus.err, bus.in_ready, bus.err_cnt);
        end
        q.delete();
        ec = 0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_stale[%0d] got out_valid=%b exp 0", i, bus.out_valid);
            end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        ecnt          = 0;
        ec            = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 3'b000;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;
        test_reset();
        test_arith();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound on total run time
    initial begin
        #1000000;
        $display("FAIL watchdog run did not complete, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
